// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file micro-op sequencer:
// op codes, register codes, register count and FSM state encodings.
package rf_seq_pkg;

    typedef enum logic [1:0] {
        OP_LDI = 2'd0,
        OP_CLR = 2'd1,
        OP_MOV = 2'd2,
        OP_SWP = 2'd3
    } op_t;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_B = 3'd1;
    localparam logic [2:0] REG_C = 3'd2;
    localparam logic [2:0] REG_D = 3'd3;
    localparam logic [2:0] REG_F = 3'd4;

    localparam int REG_COUNT = 5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_WR0  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;

endpackage

// File: rtl/rf_seq_if.sv
// Command handshake and status between the decode stage (master) and the sequencer (slave).
interface rf_seq_if #(parameter int W = 8);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_dst;
    logic [2:0]   cmd_src;
    logic [W-1:0] cmd_imm;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
        output cmd_ready, busy, done, err
    );

endinterface

// File: rtl/rf_sel_dec.sv
// Register code to one-hot select decoder; codes at or above NREG select nothing.
module rf_sel_dec #(
    parameter int NREG = 5
) (
    input  logic [2:0] code,
    input  logic       en,
    output logic [4:0] sel,
    output logic       invalid
);

    logic out_of_range;

    always_comb begin
        out_of_range = (code >= 3'(NREG));
        invalid      = en && out_of_range;
        sel          = (en && !out_of_range) ? (5'(1) << code) : '0;
    end

endmodule

// File: rtl/rf_seq.sv
// Micro-op sequencer: turns LDI/CLR/MOV/SWP commands into register-file
// load/output enable sequences. Outputs decode only from registered state.
module rf_seq
    import rf_seq_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREG = REG_COUNT
) (
    input  logic         clk,
    input  logic         rst,
    rf_seq_if.slave      cmd,
    input  logic [W-1:0] p,
    output logic [W-1:0] d,
    output logic         ai,
    output logic         bi,
    output logic         ci,
    output logic         di,
    output logic         fi,
    output logic         ao,
    output logic         bo,
    output logic         co,
    output logic         doe,  // D output enable ("do" is a reserved word)
    output logic         fo
);

    logic [2:0]   state;
    op_t          op_r;
    logic [2:0]   dst_r;
    logic [2:0]   src_r;
    logic [W-1:0] imm_r;
    logic [W-1:0] t0;
    logic [W-1:0] t1;
    logic         done_r;
    logic         err_r;

    logic         legal_acc;
    logic         acc_write_only;
    logic         ld_en;
    logic         oe_en;
    logic [2:0]   ld_code;
    logic [2:0]   oe_code;
    logic [4:0]   ld_sel;
    logic [4:0]   oe_sel;
    logic         ld_inv;
    logic         oe_inv;

    // cmd_src only matters for the ops that read a source register
    always_comb begin
        acc_write_only = (op_t'(cmd.cmd_op) == OP_LDI) || (op_t'(cmd.cmd_op) == OP_CLR);
        legal_acc      = (cmd.cmd_dst < 3'(NREG)) && (acc_write_only || (cmd.cmd_src < 3'(NREG)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_r   <= OP_LDI;
            dst_r  <= '0;
            src_r  <= '0;
            imm_r  <= '0;
            t0     <= '0;
            t1     <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r  <= op_t'(cmd.cmd_op);
                        dst_r <= cmd.cmd_dst;
                        src_r <= cmd.cmd_src;
                        imm_r <= cmd.cmd_imm;
                        if (!legal_acc) begin
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else if (acc_write_only) begin
                            state <= S_WR0;
                        end else begin
                            state <= S_RD0;
                        end
                    end
                end
                S_RD0: begin
                    t0    <= p;
                    state <= (op_r == OP_MOV) ? S_WR0 : S_RD1;
                end
                S_RD1: begin
                    t1    <= p;
                    state <= S_WR0;
                end
                S_WR0: begin
                    if (op_r == OP_SWP) begin
                        state <= S_WR1;
                    end else begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end
                end
                S_WR1: begin
                    state  <= S_IDLE;
                    done_r <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // SWP writes back to src in WR1 and reads dst in RD1; everything else targets dst/src directly
    always_comb begin
        ld_en   = (state == S_WR0) || (state == S_WR1);
        ld_code = (state == S_WR1) ? src_r : dst_r;
        oe_en   = (state == S_RD0) || (state == S_RD1);
        oe_code = (state == S_RD0) ? src_r : dst_r;
    end

    rf_sel_dec #(.NREG(NREG)) u_ld_dec (
        .code    (ld_code),
        .en      (ld_en),
        .sel     (ld_sel),
        .invalid (ld_inv)
    );

    rf_sel_dec #(.NREG(NREG)) u_oe_dec (
        .code    (oe_code),
        .en      (oe_en),
        .sel     (oe_sel),
        .invalid (oe_inv)
    );

    assign {fi, di, ci, bi, ai} = ld_sel;
    assign {fo, doe, co, bo, ao} = oe_sel;

    always_comb begin
        d = '0;
        if (|ld_sel) begin
            if (state == S_WR1)
                d = t1;
            else if (op_r == OP_LDI)
                d = imm_r;
            else if (op_r != OP_CLR)
                d = t0;
        end
    end

    assign cmd.cmd_ready = (state == S_IDLE);
    assign cmd.busy      = (state != S_IDLE);
    assign cmd.done      = done_r;
    assign cmd.err       = err_r;

    // Illegal codes are filtered at accept, so a live select never sees one
    a_no_bad_sel : assert property (@(posedge clk) disable iff (rst) !ld_inv && !oe_inv);

endmodule
